// File: rtl/ula_nibble_seq.sv
// ula_nibble_seq: drives one 4-bit ula_74181 slice nibble-serially (LSB first)
// to perform a WIDTH-bit operation, chaining the ALU carry between nibbles and
// assembling the result together with carry, equality and zero flags.
module ula_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cin,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout,
  input  logic             alu_aeqb,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_cout,
  output logic             res_eq,
  output logic             res_zero
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB) + 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;     // operands, shifted right one nibble per step
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_reg;        // carry-in presented to the ALU this step
  logic [IW-1:0]    idx_reg;          // current nibble index
  logic             eq_acc_reg;       // running AND of alu_aeqb
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] result_final;     // result including the nibble being captured now

  assign accept    = start && (state_reg == IDLE);
  assign last_step = (state_reg == RUN) && (idx_reg == LAST);

  // The ALU sees the low nibble of the shifting operand registers, so these
  // outputs naturally hold their last value outside RUN.
  assign alu_a   = a_reg[3:0];
  assign alu_b   = b_reg[3:0];
  assign alu_s   = s_reg;
  assign alu_m   = m_reg;
  assign alu_cin = carry_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state_reg)
      IDLE:    ready = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, nibble stepping and carry forwarding (no polarity change).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= '0;
      m_reg      <= 1'b0;
      carry_reg  <= 1'b0;
      idx_reg    <= '0;
      eq_acc_reg <= 1'b0;
    end else if (accept) begin
      a_reg      <= op_a;
      b_reg      <= op_b;
      s_reg      <= op_s;
      m_reg      <= op_m;
      carry_reg  <= op_cin;
      idx_reg    <= '0;
      eq_acc_reg <= 1'b1;
    end else if (state_reg == RUN) begin
      eq_acc_reg <= eq_acc_reg & alu_aeqb;
      idx_reg    <= idx_reg + 1'b1;
      if (!last_step) begin
        a_reg     <= a_reg >> 4;
        b_reg     <= b_reg >> 4;
        carry_reg <= alu_cout;
      end
    end
  end

  // Final result with the top nibble taken straight from the ALU, for the zero flag.
  always_comb begin
    result_final = result;
    result_final[WIDTH-4 +: 4] = alu_f;
  end

  // Result assembly: each RUN edge writes the current nibble; flags settle on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      res_cout <= 1'b0;
      res_eq   <= 1'b0;
      res_zero <= 1'b0;
    end else if (state_reg == RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx_reg == IW'(i)) result[4*i +: 4] <= alu_f;
      end
      if (last_step) begin
        res_cout <= alu_cout;
        res_eq   <= eq_acc_reg & alu_aeqb;
        res_zero <= (result_final == '0);
      end
    end
  end

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Bench for ula_nibble_seq: a behavioural 74181 nibble model closes the loop,
// and a wide-word reference fills a scoreboard queue checked at each done pulse.
module tb_ula_nibble_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ready;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0, op_cin = 1'b0;
  logic [3:0]   alu_a, alu_b, alu_s;
  logic         alu_m, alu_cin;
  logic [3:0]   alu_f;
  logic         alu_cout, alu_aeqb;
  logic         done;
  logic [W-1:0] result;
  logic         res_cout, res_eq, res_zero;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         eq;
    logic         zero;
  } exp_t;
  exp_t sb[$];

  // Per-cycle observations of the ALU interface for the last run_op.
  logic [3:0] obs_a   [0:19];
  logic [3:0] obs_b   [0:19];
  logic       obs_cin [0:19];
  logic       obs_cout[0:19];

  ula_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb),
    .done(done), .result(result), .res_cout(res_cout), .res_eq(res_eq), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  // 74181 logic-mode functions, active-high data.
  function automatic logic [W-1:0] lfn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    case (s)
      4'd0:  return ~a;
      4'd1:  return ~(a | b);
      4'd2:  return ~a & b;
      4'd3:  return '0;
      4'd4:  return ~(a & b);
      4'd5:  return ~b;
      4'd6:  return a ^ b;
      4'd7:  return a & ~b;
      4'd8:  return ~a | b;
      4'd9:  return ~(a ^ b);
      4'd10: return b;
      4'd11: return a & b;
      4'd12: return '1;
      4'd13: return a | ~b;
      4'd14: return a | b;
      default: return a;
    endcase
  endfunction

  // ALU slice model: arithmetic is X plus Y plus carry, Cn and Cn+4 active-low;
  // the A=B output is modelled as an ideal nibble comparator.
  logic [3:0] mx, my;
  logic [4:0] msum;
  logic [W-1:0] mlog;
  always_comb begin
    mx       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    my       = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    msum     = {1'b0, mx} + {1'b0, my} + {4'b0, ~alu_cin};
    mlog     = lfn({{(W-4){1'b0}}, alu_a}, {{(W-4){1'b0}}, alu_b}, alu_s);
    alu_f    = alu_m ? mlog[3:0] : msum[3:0];
    alu_cout = ~msum[4];
    alu_aeqb = (alu_a == alu_b);
  end

  // Whole-word reference: one wide add instead of a nibble chain.
  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic m, input logic cin);
    logic [W-1:0] x, y;
    logic [W:0]   sum;
    exp_t e;
    x = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    y = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~cin};
    e.res  = m ? lfn(a, b, s) : sum[W-1:0];
    e.cout = ~sum[W];
    e.eq   = (a == b);
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cin);
    exp_t e, got;
    int n;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_before_start got=%b want=1", ready); end
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin; start = 1'b1;
    sb.push_back(ref_op(a, b, s, m, cin));
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 19) begin
      obs_a[n] = alu_a; obs_b[n] = alu_b; obs_cin[n] = alu_cin; obs_cout[n] = alu_cout;
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_timeout cycles=%0d want=%0d", n, NIB + 1);
    end else begin
      got = '{res: result, cout: res_cout, eq: res_eq, zero: res_zero};
      $display("op a=%h b=%h s=%b m=%b cin=%b -> result=%h cout=%b eq=%b zero=%b (want %h %b %b %b) cycle=%0d",
               a, b, s, m, cin, result, res_cout, res_eq, res_zero, e.res, e.cout, e.eq, e.zero, n);
      if (got.res !== e.res) begin errors++; $display("FAIL result got=%h want=%h", got.res, e.res); end
      checks++;
      if (got.cout !== e.cout) begin errors++; $display("FAIL res_cout got=%b want=%b", got.cout, e.cout); end
      checks++;
      if (got.eq !== e.eq) begin errors++; $display("FAIL res_eq got=%b want=%b", got.eq, e.eq); end
      checks++;
      if (got.zero !== e.zero) begin errors++; $display("FAIL res_zero got=%b want=%b", got.zero, e.zero); end
      checks++;
      if (n != NIB + 1) begin errors++; $display("FAIL done_latency got=%0d want=%0d", n, NIB + 1); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++; $display("FAIL after_done done=%b ready=%b want done=0 ready=1", done, ready);
      end
    end
  endtask

  task automatic test_reset;
    int dones;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== '0 || res_cout !== 1'b0 || res_eq !== 1'b0 ||
        res_zero !== 1'b0 || alu_a !== 4'h0 || alu_b !== 4'h0 || alu_s !== 4'h0 || alu_m !== 1'b0 || alu_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b done=%b result=%h alu_a=%h alu_b=%h alu_s=%h want 1 0 0000 0 0 0",
               ready, done, result, alu_a, alu_b, alu_s);
    end
    $display("reset state ready=%b done=%b result=%h", ready, done, result);
  endtask

  task automatic test_reset_mid_run;
    int dones;
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h1111; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;       // cycle 1, step 0
    @(negedge clk);                     // cycle 2, step 1
    @(negedge clk);                     // cycle 3, step 2
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_run ready=%b done=%b result=%h want 1 0 0000", ready, done, result);
    end
    $display("reset mid-run ready=%b done=%b result=%h", ready, done, result);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (done === 1'b1) dones++; end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL no_done_after_reset got=%0d want=0", dones); end
  endtask

  task automatic test_nibble_order;
    logic [3:0] wa [1:4];
    logic [3:0] wb [1:4];
    wa = '{4'h4, 4'h3, 4'h2, 4'h1};
    wb = '{4'hD, 4'hC, 4'hB, 4'hA};
    run_op(16'h1234, 16'hABCD, 4'b0110, 1'b1, 1'b1);
    for (int k = 1; k <= NIB; k++) begin
      checks++;
      if (obs_a[k] !== wa[k] || obs_b[k] !== wb[k]) begin
        errors++; $display("FAIL nibble_order cycle=%0d got a=%h b=%h want a=%h b=%h", k, obs_a[k], obs_b[k], wa[k], wb[k]);
      end
    end
  endtask

  task automatic test_logic_xor;
    run_op(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1);
    checks++;
    if (result !== 16'hAA55 || res_zero !== 1'b0 || res_eq !== 1'b0) begin
      errors++; $display("FAIL xor_const result=%h zero=%b eq=%b want AA55 0 0", result, res_zero, res_eq);
    end
  endtask

  task automatic test_carry_chain;
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    checks++;
    if (result !== 16'h0000 || res_zero !== 1'b1 || res_cout !== 1'b0) begin
      errors++; $display("FAIL carry_const result=%h zero=%b cout=%b want 0000 1 0", result, res_zero, res_cout);
    end
    checks++;
    if (obs_cin[1] !== 1'b1) begin errors++; $display("FAIL carry_first_cin got=%b want=1", obs_cin[1]); end
    for (int k = 2; k <= NIB; k++) begin
      checks++;
      if (obs_cin[k] !== obs_cout[k-1]) begin
        errors++; $display("FAIL carry_forward step=%0d got=%b want=%b", k, obs_cin[k], obs_cout[k-1]);
      end
    end
    // Plain add with carry propagating out of the top nibble.
    run_op(16'h8001, 16'h8FFF, 4'b1001, 1'b0, 1'b0);
  endtask

  task automatic test_equality;
    run_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b1, 1'b1);
    checks++;
    if (res_eq !== 1'b1 || result !== 16'h0000) begin
      errors++; $display("FAIL eq_equal eq=%b result=%h want 1 0000", res_eq, result);
    end
    run_op(16'h3C3C, 16'h3C3D, 4'b0110, 1'b1, 1'b1);
    checks++;
    if (res_eq !== 1'b0) begin errors++; $display("FAIL eq_differ eq=%b want 0", res_eq); end
  endtask

  task automatic test_back_to_back;
    int dones, n, busy_bad;
    logic [W-1:0] a2;
    @(negedge clk);
    op_m = 1'b1; op_s = 4'b1111; op_b = '0; op_cin = 1'b1; op_a = 16'h1000; start = 1'b1;
    dones = 0; busy_bad = 0; a2 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (c < 6 && ready !== 1'b0) busy_bad++;
      op_a = 16'h1000 + 16'(c);
      if (c == 6) a2 = op_a;
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL b2b_done_count got=%0d want=1", dones); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL b2b_ready_busy got=%0d bad cycles want=0", busy_bad); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_cycle6 got=%b want=1", ready); end
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 19) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || result !== a2 || n != NIB + 1) begin
      errors++; $display("FAIL b2b_second result=%h want=%h done=%b cycle=%0d", result, a2, done, n);
    end
    $display("back-to-back second result=%h want=%h cycle=%0d", result, a2, n);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_reset_mid_run;
    test_nibble_order;
    test_logic_xor;
    test_carry_chain;
    test_equality;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
